uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the baud_rate_generator / TX path. It derives bit timing from its own clock-cycle counter, built from the same CLOCK_FREQ/BAUD_RATE parameters as the baud generator. It samples each bit at mid-period and presents each received byte with a one-cycle valid strobe. It also flags framing errors. It sits between the synchronised serial input pin and the byte-level consumer (FIFO/controller).

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 921600, serial bit rate in bits/s; CPB = CLOCK_FREQ/BAUD_RATE (integer division, 54 at defaults), HALF = CPB/2 (27)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  last correctly framed byte, LSB received first
rx_valid  output  1  one-cycle strobe: rx_data updated this cycle
frame_err  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; counters=0; shift reg=0; rx_data=8'h00; rx_valid=0; frame_err=0; busy=0; both synchroniser flops=1.
- Input: 2-flop synchroniser rx -> rx_s (2-cycle latency). All decisions use rx_s only.
- Elaboration check: CPB < 4 is illegal -> $error/$fatal.
- Cycle counter is sized ceil(log2(CPB)); it clears on every state change and at each bit sample.
- IDLE: rx_s==0 -> START. Call this cycle t0 (first cycle with rx_s low).
- START: at t0+HALF, sample rx_s. 0 -> DATA, bit index 0. 1 -> glitch, return to IDLE; no strobes.
- DATA: sample at t0+HALF+k*CPB for k=1..8. Shift right, new bit into bit 7, so LSB-first order yields the correct byte after 8 samples. After k=8 -> STOP.
- STOP: sample at t0+HALF+9*CPB.
  - rx_s=1: next cycle rx_data<=shift reg and rx_valid=1 for exactly 1 cycle; -> IDLE.
  - rx_s=0: next cycle frame_err=1 for exactly 1 cycle; rx_data unchanged; rx_valid stays 0; -> WAIT_HIGH.
- WAIT_HIGH: remain until rx_s==1, then -> IDLE. Prevents a break condition from retriggering frames.
- Latency: rx_valid is high in cycle t0+HALF+9*CPB+1, i.e. t0+514 at defaults. No tolerance; the bench checks exactly.
- Back-to-back frames: the start bit may follow the stop-bit sample with zero idle cycles. IDLE catches the falling edge in the first cycle rx_s is low, so consecutive frames are never lost.
- rx_valid and frame_err are never high together. No output handshake exists; the consumer must take rx_data on rx_valid, and rx_data holds until the next valid frame.
- Reset mid-frame: abort immediately with all outputs at reset values the cycle after. Partial byte discarded; no strobe.
- busy is combinational from state: 1 in START/DATA/STOP/WAIT_HIGH.

Test Plan:
1. Reset: rst=0 for 3 cycles, rx=1 -> rx_data=8'h00, rx_valid=0, frame_err=0, busy=0. rst=1 with rx=1 for 200 cycles -> no change.
2. Single frame: send 8'hA5 at 54 clk/bit (start, 1,0,1,0,0,1,0,1, stop) -> exactly one rx_valid pulse at t0+514, rx_data=8'hA5, frame_err never high. busy rises at t0+1 and falls after the valid.
3. Glitch: rx low for 10 cycles, then high -> no rx_valid/frame_err; busy high then low by t0+28. A following frame 8'h3C is received with rx_data=8'h3C.
4. Framing error: 8'h00 with line held low for 20 bit periods -> one frame_err pulse at t0+514, rx_valid=0, rx_data stays 8'h3C. busy stays high until the line returns high. A following frame 8'hFF yields rx_data=8'hFF.
5. Back-to-back: 8'h55 then 8'h0F, zero idle gap -> two rx_valid pulses exactly 540 cycles apart with rx_data 8'h55 then 8'h0F; no frame_err.
6. Reset mid-frame: assert rst=0 during data bit 3 of 8'hC3 -> next cycle busy=0, rx_valid=0, rx_data=8'h00, with no strobe for the aborted byte. Release rst=0 with rx=1, then send 8'h81 -> rx_data=8'h81.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte strobes of the 8N1 UART receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling from a clock-cycle counter
module uart_rx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 921600
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus
);
  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    rx_data_q, rx_data_next;
  logic          rx_valid_q, rx_valid_next;
  logic          frame_err_q, frame_err_next;
  logic          rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      rx_data_q   <= rx_data_next;
      rx_valid_q  <= rx_valid_next;
      frame_err_q <= frame_err_next;
      rx_meta     <= bus.rx;
      rx_s        <= rx_meta;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    rx_data_next   = rx_data_q;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-period is treated as a glitch
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = 3'd0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CPB_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CPB_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_data_next  = shift;
            rx_valid_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until a break releases the line so it cannot start a frame
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a timing/byte reference model
module tb_uart_rx;
  localparam int CLOCK_FREQ = 50000000;
  localparam int BAUD_RATE  = 921600;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = CPB / 2;
  localparam int SYNC       = 2;
  // drive edge -> strobe visible: synchroniser, half bit, nine bit periods, output register
  localparam int LAT        = SYNC + HALF + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  uart_rx_if bus();

  uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         valid_t[$];
  logic [7:0] valid_d[$];
  int         err_t[$];
  int         rise_t[$];
  int         fall_t[$];
  int         both_hi = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      valid_t.push_back(cyc);
      valid_d.push_back(bus.rx_data);
    end
    if (bus.frame_err === 1'b1) err_t.push_back(cyc);
    if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) both_hi++;
    if (bus.busy === 1'b1 && busy_prev === 1'b0) rise_t.push_back(cyc);
    if (bus.busy === 1'b0 && busy_prev === 1'b1) fall_t.push_back(cyc);
    busy_prev = bus.busy;
  end

  task automatic clear_q();
    valid_t.delete();
    valid_d.delete();
    err_t.delete();
    rise_t.delete();
    fall_t.delete();
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is positioned #1 after a clock edge; t is the edge the start bit was driven after
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t);
    t = cyc;
    bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    bus.rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.rx_data); else passed++;
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); else passed++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_q();
    idle(200);
    total++; if (valid_t.size() != 0) $display("FAIL idle_valid: got %0d pulses expected 0", valid_t.size()); else passed++;
    total++; if (err_t.size() != 0) $display("FAIL idle_ferr: got %0d pulses expected 0", err_t.size()); else passed++;
    total++; if (rise_t.size() != 0) $display("FAIL idle_busy: got %0d rises expected 0", rise_t.size()); else passed++;
    total++; if (bus.rx_data !== 8'h00) $display("FAIL idle_data: got %h expected 00", bus.rx_data); else passed++;
  endtask

  task automatic test_single_frame();
    int t;
    clear_q();
    idle(5);
    send_frame(8'hA5, 1'b1, t);
    idle(10);
    total++; if (valid_t.size() != 1) $display("FAIL single_count: got %0d expected 1", valid_t.size()); else passed++;
    if (valid_t.size() > 0) begin
      total++; if (valid_t[0] != t + LAT) $display("FAIL single_time: got %0d expected %0d", valid_t[0] - t, LAT); else passed++;
      total++; if (valid_d[0] !== 8'hA5) $display("FAIL single_data: got %h expected a5", valid_d[0]); else passed++;
    end
    total++; if (err_t.size() != 0) $display("FAIL single_ferr: got %0d expected 0", err_t.size()); else passed++;
    total++; if (rise_t.size() != 1 || rise_t[0] != t + SYNC + 1) $display("FAIL single_busy_rise: got %0d rises expected 1 at +%0d", rise_t.size(), SYNC + 1); else passed++;
    total++; if (fall_t.size() != 1 || fall_t[0] != t + LAT) $display("FAIL single_busy_fall: got %0d falls expected 1 at +%0d", fall_t.size(), LAT); else passed++;
  endtask

  task automatic test_glitch();
    int t;
    clear_q();
    t = cyc;
    bus.rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    idle(60);
    total++; if (valid_t.size() != 0 || err_t.size() != 0) $display("FAIL glitch_strobe: got %0d/%0d expected 0/0", valid_t.size(), err_t.size()); else passed++;
    total++; if (rise_t.size() != 1 || rise_t[0] != t + SYNC + 1) $display("FAIL glitch_busy_rise: got %0d rises expected 1 at +%0d", rise_t.size(), SYNC + 1); else passed++;
    total++; if (fall_t.size() != 1 || fall_t[0] != t + SYNC + HALF + 1) $display("FAIL glitch_busy_fall: got %0d falls expected 1 at +%0d", fall_t.size(), SYNC + HALF + 1); else passed++;
    clear_q();
    send_frame(8'h3C, 1'b1, t);
    idle(10);
    total++; if (valid_t.size() != 1 || bus.rx_data !== 8'h3C) $display("FAIL glitch_next: got %0d pulses data %h expected 1 data 3c", valid_t.size(), bus.rx_data); else passed++;
  endtask

  task automatic test_frame_err();
    int t;
    int m;
    clear_q();
    send_frame(8'h00, 1'b0, t);
    bus.rx = 1'b0;
    repeat (10 * CPB) @(posedge clk);
    #1;
    total++; if (err_t.size() != 1) $display("FAIL ferr_count: got %0d expected 1", err_t.size()); else passed++;
    if (err_t.size() > 0) begin
      total++; if (err_t[0] != t + LAT) $display("FAIL ferr_time: got %0d expected %0d", err_t[0] - t, LAT); else passed++;
    end
    total++; if (valid_t.size() != 0) $display("FAIL ferr_valid: got %0d expected 0", valid_t.size()); else passed++;
    total++; if (bus.rx_data !== 8'h3C) $display("FAIL ferr_data: got %h expected 3c", bus.rx_data); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL ferr_busy_hold: got %b expected 1", bus.busy); else passed++;
    m = cyc;
    idle(10);
    total++; if (fall_t.size() != 1 || fall_t[0] != m + SYNC + 1) $display("FAIL ferr_busy_fall: got %0d falls expected 1 at +%0d", fall_t.size(), SYNC + 1); else passed++;
    clear_q();
    send_frame(8'hFF, 1'b1, t);
    idle(10);
    total++; if (valid_t.size() != 1 || bus.rx_data !== 8'hFF) $display("FAIL ferr_next: got %0d pulses data %h expected 1 data ff", valid_t.size(), bus.rx_data); else passed++;
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    clear_q();
    idle(3);
    send_frame(8'h55, 1'b1, t1);
    send_frame(8'h0F, 1'b1, t2);
    idle(10);
    total++; if (valid_t.size() != 2) $display("FAIL b2b_count: got %0d expected 2", valid_t.size()); else passed++;
    if (valid_t.size() == 2) begin
      total++; if (valid_t[0] != t1 + LAT) $display("FAIL b2b_time0: got %0d expected %0d", valid_t[0] - t1, LAT); else passed++;
      total++; if (valid_t[1] - valid_t[0] != 10 * CPB) $display("FAIL b2b_gap: got %0d expected %0d", valid_t[1] - valid_t[0], 10 * CPB); else passed++;
      total++; if (valid_d[0] !== 8'h55) $display("FAIL b2b_data0: got %h expected 55", valid_d[0]); else passed++;
      total++; if (valid_d[1] !== 8'h0F) $display("FAIL b2b_data1: got %h expected 0f", valid_d[1]); else passed++;
    end
    total++; if (err_t.size() != 0) $display("FAIL b2b_ferr: got %0d expected 0", err_t.size()); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int t;
    b = 8'hC3;
    clear_q();
    idle(3);
    bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    bus.rx = b[3];
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", bus.rx_valid); else passed++;
    total++; if (bus.rx_data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", bus.rx_data); else passed++;
    bus.rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(600);
    total++; if (valid_t.size() != 0 || err_t.size() != 0) $display("FAIL rstmid_strobe: got %0d/%0d expected 0/0", valid_t.size(), err_t.size()); else passed++;
    clear_q();
    send_frame(8'h81, 1'b1, t);
    idle(10);
    total++; if (valid_t.size() != 1 || bus.rx_data !== 8'h81) $display("FAIL rstmid_next: got %0d pulses data %h expected 1 data 81", valid_t.size(), bus.rx_data); else passed++;
  endtask

  task automatic test_random();
    int         exp_t[$];
    logic [7:0] exp_d[$];
    int         exp_e[$];
    logic [7:0] last_good;
    logic [7:0] b;
    logic       stop;
    int         t;
    last_good = 8'h81;
    clear_q();
    idle(4);
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, t);
      if (stop) begin
        exp_t.push_back(t + LAT);
        exp_d.push_back(b);
        last_good = b;
      end else begin
        exp_e.push_back(t + LAT);
      end
      idle($urandom_range(1, 20));
    end
    idle(10);
    total++; if (valid_t.size() != exp_t.size()) $display("FAIL rand_valid_count: got %0d expected %0d", valid_t.size(), exp_t.size()); else passed++;
    total++; if (err_t.size() != exp_e.size()) $display("FAIL rand_ferr_count: got %0d expected %0d", err_t.size(), exp_e.size()); else passed++;
    for (int i = 0; i < exp_t.size() && i < valid_t.size(); i++) begin
      total++; if (valid_t[i] != exp_t[i] || valid_d[i] !== exp_d[i]) $display("FAIL rand_frame%0d: got t=%0d d=%h expected t=%0d d=%h", i, valid_t[i], valid_d[i], exp_t[i], exp_d[i]); else passed++;
    end
    for (int i = 0; i < exp_e.size() && i < err_t.size(); i++) begin
      total++; if (err_t[i] != exp_e[i]) $display("FAIL rand_ferr%0d: got t=%0d expected t=%0d", i, err_t[i], exp_e[i]); else passed++;
    end
    total++; if (bus.rx_data !== last_good) $display("FAIL rand_hold: got %h expected %h", bus.rx_data, last_good); else passed++;
    total++; if (both_hi != 0) $display("FAIL strobe_overlap: got %0d cycles expected 0", both_hi); else passed++;
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
